// File: rtl/xalu_ise_issue.sv
// Core-side issuer for the custom-opcode ISE datapath: decodes one custom-0..3
// R-type instruction, holds the request on the ISE port and returns the result.
module xalu_ise_issue #(
  parameter int         TIMEOUT   = 8,
  parameter logic [3:0] CUSTOM_EN = 4'b1111
) (
  input  logic        ise_clk,
  input  logic        ise_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_illegal,
  output logic        busy,
  output logic [5:0]  ise_fn,
  output logic [6:0]  ise_imm,
  output logic [31:0] ise_in1,
  output logic [31:0] ise_in2,
  output logic        ise_val,
  input  logic        ise_oval,
  input  logic [31:0] ise_out
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [4:0]  rd_q, rd_nx;
  logic [5:0]  fn_q, fn_nx;
  logic [6:0]  imm_q, imm_nx;
  logic [31:0] in1_q, in1_nx;
  logic [31:0] in2_q, in2_nx;
  logic [31:0] data_q, data_nx;
  logic        ill_q, ill_nx;
  logic        dec_custom;
  logic [1:0]  dec_sel;
  logic        unused_fields;

  // Returns {custom, sel}; an opcode whose enable bit is clear decodes as non-custom.
  function automatic logic [2:0] decode_op(input logic [6:0] op);
    logic [2:0] d;
    d = 3'b000;
    case (op)
      7'b0001011: d = {CUSTOM_EN[0], 2'd0};
      7'b0101011: d = {CUSTOM_EN[1], 2'd1};
      7'b1011011: d = {CUSTOM_EN[2], 2'd2};
      7'b1111011: d = {CUSTOM_EN[3], 2'd3};
      default:    d = 3'b000;
    endcase
    return d;
  endfunction

  assign {dec_custom, dec_sel} = decode_op(req_instr[6:0]);

  // rs1/rs2 register-index fields are not needed: operand values arrive separately.
  assign unused_fields = ^req_instr[24:15];

  always_ff @(posedge ise_clk or negedge ise_rst) begin
    if (!ise_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Data registers are reset too so that every output reads 0 while in reset.
  always_ff @(posedge ise_clk or negedge ise_rst) begin
    if (!ise_rst) begin
      cnt    <= '0;
      rd_q   <= '0;
      fn_q   <= '0;
      imm_q  <= '0;
      in1_q  <= '0;
      in2_q  <= '0;
      data_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      rd_q   <= rd_nx;
      fn_q   <= fn_nx;
      imm_q  <= imm_nx;
      in1_q  <= in1_nx;
      in2_q  <= in2_nx;
      data_q <= data_nx;
      ill_q  <= ill_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rd_nx    = rd_q;
    fn_nx    = fn_q;
    imm_nx   = imm_q;
    in1_nx   = in1_q;
    in2_nx   = in2_q;
    data_nx  = data_q;
    ill_nx   = ill_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          rd_nx  = req_instr[11:7];
          fn_nx  = {1'b0, req_instr[14:12], dec_sel};
          imm_nx = req_instr[31:25];
          in1_nx = req_rs1;
          in2_nx = req_rs2;
          cnt_nx = '0;
          if (dec_custom) begin
            state_nx = ISSUE;
          end else begin
            data_nx  = '0;
            ill_nx   = 1'b1;
            state_nx = RESP;
          end
        end
      end
      ISSUE: begin
        // A result in the final timeout cycle still wins over the timeout.
        if (ise_oval) begin
          data_nx  = (rd_q == 5'd0) ? 32'd0 : ise_out;
          ill_nx   = 1'b0;
          state_nx = RESP;
        end else if (cnt == CNT_LAST) begin
          data_nx  = '0;
          ill_nx   = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // req_ready is gated by reset so it reads 0 while reset is held.
  assign req_ready   = ise_rst & (state == IDLE);
  assign ise_val     = (state == ISSUE);
  assign rsp_valid   = (state == RESP);
  assign busy        = (state != IDLE);
  assign ise_fn      = fn_q;
  assign ise_imm     = imm_q;
  assign ise_in1     = in1_q;
  assign ise_in2     = in2_q;
  assign rsp_rd      = rd_q;
  assign rsp_data    = data_q;
  assign rsp_illegal = ill_q;

endmodule

// File: doc/xalu_ise_issue.md
Name: xalu_ise_issue

Overview:
- Core-side issuer for the custom-opcode ISE datapath; it is the initiator end of the ise_val/ise_oval interface.
- Accepts one custom-0..3 R-type instruction with its operand values from the core and decodes it into ise_fn/ise_imm.
- Drives the ISE ALU with a held request and waits for ise_oval, with a timeout.
- Returns a registered writeback response or an illegal-instruction flag to the core over a valid/ready handshake.

Parameters:
- TIMEOUT, 8: cycles ise_val is held without ise_oval before the op is declared illegal; legal range 1..255.
- CUSTOM_EN, 4'b1111: bit n enables opcode custom-n. A disabled opcode is treated as non-custom.

Ports:
- ise_clk  in  1  clock.
- ise_rst  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents an instruction.
- req_ready  out  1  issuer accepts the instruction this cycle.
- req_instr  in  32  instruction word.
- req_rs1  in  32  rs1 value.
- req_rs2  in  32  rs2 value.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core consumes the response.
- rsp_rd  out  5  destination register, instr[11:7].
- rsp_data  out  32  result.
- rsp_illegal  out  1  op was not executed.
- busy  out  1  state is not IDLE.
- ise_fn  out  6  {1'b0, funct3, opcode-select[1:0]}.
- ise_imm  out  7  funct7, instr[31:25].
- ise_in1  out  32  registered rs1.
- ise_in2  out  32  registered rs2.
- ise_val  out  1  request valid.
- ise_oval  in  1  ALU accepts and returns a result.
- ise_out  in  32  ALU result.

Behaviour:
- Reset: ise_rst low asynchronously forces state IDLE.
  - All outputs are 0 during reset, except req_ready, which is 1 once reset is released.
  - Timeout counter is 0.
  - Reset mid-operation abandons the op. No response is produced.
- Opcode decode on instr[6:0]:
  - 0001011 gives sel 00, 0101011 gives 01, 1011011 gives 10, 1111011 gives 11.
  - Any other value, or an opcode with CUSTOM_EN bit clear, is non-custom.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture instr fields, rs1 and rs2 into registers.
  - Custom opcode: next state ISSUE.
  - Non-custom opcode: next state RESP with rsp_illegal=1 and rsp_data=0. Latency is 1 cycle; ise_val is never asserted.
- ISSUE:
  - ise_val = 1. ise_fn, ise_imm, ise_in1 and ise_in2 are driven from registers and stay stable until the state is left.
  - req_ready = 0.
  - Every cycle sample ise_oval in the same cycle as ise_val.
  - ise_oval = 1: capture ise_out into rsp_data, set rsp_illegal=0, go to RESP.
  - ise_oval = 0: increment the counter. When the counter reaches TIMEOUT-1 with oval still low, go to RESP with rsp_illegal=1 and rsp_data=0.
  - The counter clears on ISSUE entry.
  - ise_oval has priority over timeout when both occur in the final cycle.
  - ise_oval is ignored outside ISSUE.
- RESP:
  - rsp_valid = 1. rsp_rd, rsp_data and rsp_illegal are held stable until rsp_ready.
  - The cycle with rsp_valid & rsp_ready returns the block to IDLE. rsp_valid is 0 in the following cycle.
  - No new request is accepted in the handshake cycle.
- rd = x0: the op still executes, rsp_data is forced to 0, and rsp_rd = 0.
- Latency, legal op with same-cycle oval: accept cycle N, ise_val in N+1, rsp_valid in N+2.
- busy = (state != IDLE).
- Only one op is in flight; there is no buffering.

Test Plan:
- Reset: assert ise_rst low mid-ISSUE -> ise_val=0, rsp_valid=0 immediately; after release req_ready=1 and no stale response appears.
- custom-3 op, ALU model oval=1 same cycle returning in1^in2:
  - Stimulus: funct7=0000011, funct3=000, rd=5, rs1=0x12345678, rs2=0x0F0F0F0F.
  - Required: ise_fn=6'b000011, ise_imm=7'h03, ise_val at N+1.
  - Required: rsp_valid at N+2 with rsp_data=0x1D3B5977, rsp_rd=5, rsp_illegal=0.
- Opcode 0110011 (OP) -> rsp_valid at N+1, rsp_illegal=1, rsp_data=0, ise_val never high.
- custom-1 op, ALU model never asserts oval, TIMEOUT=8 -> ise_val high exactly 8 cycles, then rsp_illegal=1, rsp_data=0.
- ALU model asserts oval after 3 cycles with 0xDEADBEEF -> ise_in1/ise_in2 stable all 3 cycles, rsp_data=0xDEADBEEF, rsp_illegal=0.
- rsp_ready held low 5 cycles with req_valid continuously high -> rsp fields stable and req_ready=0 throughout; the next op is accepted only the cycle after the handshake.
